// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid: pipeline register with valid/ready handshaking and a
// 2-entry skid buffer between two pipeline stages (EXE/MEM, ID/EXE, MEM/WB).
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   flush           synchronous kill of all held entries (highest priority)
//   in_valid/ready  upstream handshake; in_ready depends only on registered state
//   in_ctrl/a/b/rd/tag   upstream payload (control, alu result, store data,
//                        destination register, instruction tag)
//   out_valid/ready downstream handshake
//   out_ctrl        control bits with KILL_MASK bits forced to 0 on bubbles
//   out_a/b/rd/tag  payload from the main register (holds on bubbles)
//   stall_cnt       saturating count of cycles with out_valid & ~out_ready
module pipe_reg_skid #(
    parameter int unsigned              DATA_W    = 32,
    parameter int unsigned              CTRL_W    = 3,
    parameter int unsigned              RD_W      = 5,
    parameter int unsigned              TAG_W     = 8,
    parameter logic [CTRL_W-1:0]        KILL_MASK = '1,
    parameter int unsigned              CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [RD_W-1:0]   out_rd,
    output logic [TAG_W-1:0]  out_tag,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_a, skid_a;
    logic [DATA_W-1:0] main_b, skid_b;
    logic [RD_W-1:0]   main_rd, skid_rd;
    logic [TAG_W-1:0]  main_tag, skid_tag;

    logic in_fire;
    logic out_fire;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid_in;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush) begin
            // Flush drops everything, including an entry offered this cycle;
            // payload registers are left untouched.
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt    = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_nxt    = FULL;
                        load_skid_in = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_nxt      = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_ctrl <= '0;
            main_a    <= '0;
            main_b    <= '0;
            main_rd   <= '0;
            main_tag  <= '0;
        end else if (load_main_in) begin
            main_ctrl <= in_ctrl;
            main_a    <= in_a;
            main_b    <= in_b;
            main_rd   <= in_rd;
            main_tag  <= in_tag;
        end else if (load_main_skid) begin
            main_ctrl <= skid_ctrl;
            main_a    <= skid_a;
            main_b    <= skid_b;
            main_rd   <= skid_rd;
            main_tag  <= skid_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_ctrl <= '0;
            skid_a    <= '0;
            skid_b    <= '0;
            skid_rd   <= '0;
            skid_tag  <= '0;
        end else if (load_skid_in) begin
            skid_ctrl <= in_ctrl;
            skid_a    <= in_a;
            skid_b    <= in_b;
            skid_rd   <= in_rd;
            skid_tag  <= in_tag;
        end
    end

    // Counts every cycle presented but not accepted; flush does not clear it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Bubbles must never assert the masked write/memory enables.
    assign out_ctrl = main_ctrl & ~(KILL_MASK & {CTRL_W{~out_valid}});
    assign out_a    = main_a;
    assign out_b    = main_b;
    assign out_rd   = main_rd;
    assign out_tag  = main_tag;

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Self-checking bench for pipe_reg_skid. Two instances share all inputs:
// dut uses the defaults, dut2 uses KILL_MASK=3'b101 and CNT_W=4.
// The reference model is a bounded FIFO queue of capacity two.
module tb_pipe_reg_skid;

    typedef struct packed {
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [7:0]  tag;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    entry_t      cur = '0;

    logic        in_ready, out_valid, in_ready2, out_valid2;
    logic [2:0]  out_ctrl, out_ctrl2;
    logic [31:0] out_a, out_b, out_a2, out_b2;
    logic [4:0]  out_rd, out_rd2;
    logic [7:0]  out_tag, out_tag2;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    entry_t      q[$];
    entry_t      last = '0;
    int unsigned cnt16 = 0;
    int unsigned cnt4  = 0;

    always #5 clk = ~clk;

    pipe_reg_skid dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(cur.ctrl), .in_a(cur.a), .in_b(cur.b), .in_rd(cur.rd), .in_tag(cur.tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_tag(out_tag),
        .stall_cnt(stall_cnt)
    );

    pipe_reg_skid #(.KILL_MASK(3'b101), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_ctrl(cur.ctrl), .in_a(cur.a), .in_b(cur.b), .in_rd(cur.rd), .in_tag(cur.tag),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_ctrl(out_ctrl2), .out_a(out_a2), .out_b(out_b2), .out_rd(out_rd2), .out_tag(out_tag2),
        .stall_cnt(stall_cnt2)
    );

    function automatic entry_t mk(input logic [7:0] tag, input logic [2:0] ctrl);
        entry_t e;
        e.ctrl = ctrl;
        e.a    = $urandom;
        e.b    = $urandom;
        e.rd   = 5'($urandom_range(0, 31));
        e.tag  = tag;
        return e;
    endfunction

    task automatic model_reset();
        q.delete();
        last  = '0;
        cnt16 = 0;
        cnt4  = 0;
    endtask

    // Advance one clock: the model consumes the inputs as they stand before the edge.
    task automatic cycle();
        bit ir, ov;
        ir = (q.size() < 2);
        ov = (q.size() > 0);
        if (ov && !out_ready) begin
            if (cnt16 < 65535) cnt16++;
            if (cnt4 < 15) cnt4++;
        end
        if (flush) begin
            q.delete();
        end else begin
            if (ov && out_ready) void'(q.pop_front());
            if (in_valid && ir) q.push_back(cur);
        end
        @(posedge clk);
        #1;
        if (q.size() > 0) last = q[0];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (out_valid !== 1'b0 || out_valid2 !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got %b/%b exp 0", out_valid, out_valid2);
        end
        n_tests++;
        if (in_ready !== 1'b1 || in_ready2 !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got %b/%b exp 1", in_ready, in_ready2);
        end
        n_tests++;
        if (out_ctrl !== 3'b000 || out_ctrl2 !== 3'b000 || out_a !== 32'h0 || out_b !== 32'h0
            || out_rd !== 5'h0 || out_tag !== 8'h0) begin
            n_fail++; $display("FAIL reset_payload got ctrl=%b/%b a=%h b=%h rd=%h tag=%h exp all 0",
                               out_ctrl, out_ctrl2, out_a, out_b, out_rd, out_tag);
        end
        n_tests++;
        if (stall_cnt !== 16'h0 || stall_cnt2 !== 4'h0) begin
            n_fail++; $display("FAIL reset_stall got %h/%h exp 0", stall_cnt, stall_cnt2);
        end
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cur = mk(8'(i), 3'b111);
            in_valid = 1'b1;
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++; $display("FAIL stream_in_ready[%0d] got %b exp 1", i, in_ready);
            end
            cycle();
            n_tests++;
            if (out_valid !== 1'b1 || out_tag !== 8'(i) || out_ctrl !== 3'b111 || out_a !== cur.a) begin
                n_fail++; $display("FAIL stream_out[%0d] got v=%b tag=%h ctrl=%b exp v=1 tag=%h ctrl=111",
                                   i, out_valid, out_tag, out_ctrl, i);
            end
            n_tests++;
            if (stall_cnt !== 16'h0) begin
                n_fail++; $display("FAIL stream_stall[%0d] got %0d exp 0", i, stall_cnt);
            end
        end
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_backpressure();
        logic [7:0] got[$];
        logic [7:0] exp_tags[3];
        exp_tags = '{8'h10, 8'h11, 8'h12};
        do_reset();
        out_ready = 1'b0;
        cur = mk(8'h10, 3'b011); in_valid = 1'b1; cycle();
        cur = mk(8'h11, 3'b101); cycle();
        cur = mk(8'h12, 3'b110);
        n_tests++;
        if (out_tag !== 8'h10 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_full got tag=%h in_ready=%b exp tag=10 in_ready=0", out_tag, in_ready);
        end
        cycle(); cycle();
        n_tests++;
        if (out_tag !== 8'h10 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold got tag=%h in_ready=%b exp tag=10 in_ready=0", out_tag, in_ready);
        end
        n_tests++;
        if (stall_cnt !== 16'd3 || 32'(stall_cnt) !== cnt16) begin
            n_fail++; $display("FAIL bp_stall got %0d exp 3", stall_cnt);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bit accept;
            accept = in_valid && in_ready;
            if (out_valid && out_ready) got.push_back(out_tag);
            cycle();
            if (accept) in_valid = 1'b0;
        end
        n_tests++;
        if (got.size() != 3) begin
            n_fail++; $display("FAIL bp_count got %0d entries exp 3", got.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (got[k] !== exp_tags[k]) begin
                    n_fail++; $display("FAIL bp_order[%0d] got %h exp %h", k, got[k], exp_tags[k]);
                end
            end
        end
        n_tests++;
        if (stall_cnt !== 16'd3) begin
            n_fail++; $display("FAIL bp_stall_final got %0d exp 3", stall_cnt);
        end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        cur = mk(8'h30, 3'b111); in_valid = 1'b1; cycle();
        cur = mk(8'h31, 3'b111); cycle();
        cur = mk(8'h20, 3'b111); flush = 1'b1; cycle();
        flush = 1'b0; in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || out_ctrl !== 3'b000 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_state got v=%b ctrl=%b rdy=%b exp v=0 ctrl=000 rdy=1",
                               out_valid, out_ctrl, in_ready);
        end
        n_tests++;
        if (out_ctrl2 !== 3'b010) begin
            n_fail++; $display("FAIL flush_ctrl_mask101 got %b exp 010", out_ctrl2);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            n_tests++;
            if (out_valid !== 1'b0 || out_tag === 8'h20) begin
                n_fail++; $display("FAIL flush_no_leak[%0d] got v=%b tag=%h exp v=0", c, out_valid, out_tag);
            end
        end
    endtask

    task automatic test_partial_kill();
        do_reset();
        out_ready = 1'b1;
        cur = mk(8'h40, 3'b111); in_valid = 1'b1; cycle();
        in_valid = 1'b0;
        n_tests++;
        if (out_ctrl2 !== 3'b111 || out_valid2 !== 1'b1) begin
            n_fail++; $display("FAIL kill_live got ctrl=%b v=%b exp 111 v=1", out_ctrl2, out_valid2);
        end
        cycle();
        n_tests++;
        if (out_valid2 !== 1'b0 || out_ctrl2 !== 3'b010 || out_ctrl !== 3'b000) begin
            n_fail++; $display("FAIL kill_bubble got v=%b ctrl2=%b ctrl=%b exp v=0 ctrl2=010 ctrl=000",
                               out_valid2, out_ctrl2, out_ctrl);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b0;
        cur = mk(8'h50, 3'b001); in_valid = 1'b1; cycle();
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) cycle();
        n_tests++;
        if (stall_cnt2 !== 4'hF) begin
            n_fail++; $display("FAIL sat_cnt4 got %h exp f", stall_cnt2);
        end
        n_tests++;
        if (stall_cnt !== 16'd20) begin
            n_fail++; $display("FAIL sat_cnt16 got %0d exp 20", stall_cnt);
        end
        flush = 1'b1; cycle(); flush = 1'b0;
        cycle();
        n_tests++;
        if (stall_cnt2 !== 4'hF || out_valid2 !== 1'b0) begin
            n_fail++; $display("FAIL sat_after_flush got cnt=%h v=%b exp cnt=f v=0", stall_cnt2, out_valid2);
        end
    endtask

    task automatic test_reset_mid_full();
        do_reset();
        out_ready = 1'b0;
        cur = mk(8'h60, 3'b111); in_valid = 1'b1; cycle();
        cur = mk(8'h61, 3'b111); cycle();
        in_valid = 1'b0;
        cycle();
        rst = 1'b1;
        #2;
        n_tests++;
        if (out_valid !== 1'b0 || out_ctrl !== 3'b000 || out_a !== 32'h0 || out_b !== 32'h0
            || out_rd !== 5'h0 || out_tag !== 8'h0 || stall_cnt !== 16'h0 || in_ready !== 1'b1
            || stall_cnt2 !== 4'h0 || out_ctrl2 !== 3'b000) begin
            n_fail++; $display("FAIL async_reset got v=%b ctrl=%b a=%h tag=%h cnt=%0d rdy=%b exp zeros rdy=1",
                               out_valid, out_ctrl, out_a, out_tag, stall_cnt, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cur = mk(8'h55, 3'b110); in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_tag !== 8'h55 || out_ctrl !== 3'b110) begin
            n_fail++; $display("FAIL post_reset_accept got v=%b tag=%h ctrl=%b exp v=1 tag=55 ctrl=110",
                               out_valid, out_tag, out_ctrl);
        end
        cycle();
    endtask

    task automatic test_random();
        entry_t f;
        bit     ov;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (!(in_valid && q.size() >= 2)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                cur = mk(8'($urandom), 3'($urandom));
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            cycle();
            ov = (q.size() > 0);
            f  = ov ? q[0] : last;
            n_tests++;
            if (out_valid !== ov || out_valid2 !== ov || in_ready !== (q.size() < 2)
                || in_ready2 !== (q.size() < 2)) begin
                n_fail++; $display("FAIL rand_hs[%0d] got v=%b rdy=%b exp v=%b rdy=%b",
                                   c, out_valid, in_ready, ov, q.size() < 2);
            end
            n_tests++;
            if (out_ctrl !== (ov ? f.ctrl : 3'b000) || out_ctrl2 !== (ov ? f.ctrl : (f.ctrl & 3'b010))) begin
                n_fail++; $display("FAIL rand_ctrl[%0d] got %b/%b exp base %b valid %b", c, out_ctrl, out_ctrl2, f.ctrl, ov);
            end
            if (ov) begin
                n_tests++;
                if (out_a !== f.a || out_b !== f.b || out_rd !== f.rd || out_tag !== f.tag || out_tag2 !== f.tag) begin
                    n_fail++; $display("FAIL rand_data[%0d] got tag=%h a=%h exp tag=%h a=%h", c, out_tag, out_a, f.tag, f.a);
                end
            end
            n_tests++;
            if (32'(stall_cnt) !== cnt16 || 32'(stall_cnt2) !== cnt4) begin
                n_fail++; $display("FAIL rand_stall[%0d] got %0d/%0d exp %0d/%0d", c, stall_cnt, stall_cnt2, cnt16, cnt4);
            end
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_partial_kill();
        test_saturation();
        test_reset_mid_full();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_reg_skid.md
Name: pipe_reg_skid

Overview:
- Parametrised successor to the fixed EXE/MEM pipeline latch.
- Carries control bits, two data words, destination register and instruction tag between any two pipeline stages.
- Adds valid/ready handshaking, a 2-entry skid buffer for back-pressure, synchronous flush with control-bit kill, and a saturating stall-cycle counter.
- Instantiated between EXE/MEM, and reusable for ID/EXE and MEM/WB.

Parameters:
- DATA_W, 32, width of each data word (alu result, store data)
- CTRL_W, 3, width of control bundle (e.g. wreg, m2reg, wmem)
- RD_W, 5, destination register index width
- TAG_W, 8, instruction tag width (type + number packed)
- KILL_MASK, {CTRL_W{1'b1}}, control bits forced to 0 at output whenever out_valid=0
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream entry present
- in_ready  out  1  block can accept this cycle
- in_ctrl  in  CTRL_W  upstream control bits
- in_a  in  DATA_W  alu result
- in_b  in  DATA_W  store data
- in_rd  in  RD_W  destination reg
- in_tag  in  TAG_W  instruction tag
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  masked control bits
- out_a  out  DATA_W  alu result
- out_b  out  DATA_W  store data
- out_rd  out  RD_W  destination reg
- out_tag  out  TAG_W  instruction tag
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Storage: main register (drives out_*) plus skid register. State is EMPTY (0 entries), ONE (main full) or FULL (main and skid full).
- Handshake:
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - in_ready = (state != FULL), decoded from registered state only. There is no combinational path from out_ready to in_ready.
  - out_valid = (state != EMPTY).
- Transitions (flush=0):
  - EMPTY: in_fire -> ONE, main<=in. Otherwise stay.
  - ONE, in_fire & out_fire: stay ONE, main<=in.
  - ONE, in_fire & !out_fire: -> FULL, skid<=in.
  - ONE, !in_fire & out_fire: -> EMPTY.
  - ONE, neither: hold.
  - FULL: in_ready=0. out_fire -> ONE, main<=skid. Otherwise hold.
- Latency: 1 cycle from in_fire to out_valid. Throughput is 1 entry/cycle while out_ready=1. Order is strictly FIFO, with no loss or duplication.
- Flush:
  - Highest priority over all handshake events.
  - Next state is EMPTY, and any entry offered on in_* that same cycle is discarded.
  - in_ready is 1 the following cycle.
  - Data registers are not cleared.
- Control masking: out_ctrl = main_ctrl & ~(KILL_MASK & {CTRL_W{~out_valid}}). A bubble never asserts a masked write/memory enable.
- Data outputs: when out_valid=0, out_a, out_b, out_rd and out_tag hold their last value, and their content is don't-care.
- Stall counter:
  - Increments by 1 every clock where out_valid & ~out_ready.
  - Saturates at 2^CNT_W-1.
  - Cleared only by rst; flush does not clear it.
- Reset (async, any time including mid-transfer):
  - State EMPTY; main and skid registers all 0; stall_cnt=0.
  - Hence out_valid=0, out_ctrl=0, out_a/out_b/out_rd/out_tag=0, and in_ready=1 immediately.
  - On deassertion, the first in_fire is accepted on the next rising edge.

Test Plan:
- Reset mid-FULL:
  - Stimulus: assert rst while holding two entries.
  - Response: out_valid, out_ctrl, out_* and stall_cnt go to 0 and in_ready goes to 1, all asynchronously before the next edge.
- Streaming:
  - Stimulus: out_ready=1, present tags 0x01..0x08 on consecutive cycles with in_ctrl=3'b111.
  - Response: out_tag 0x01..0x08 appears one cycle later, back-to-back; in_ready stays 1; stall_cnt stays 0.
- Back-pressure:
  - Stimulus: out_ready=0, send tags 0x10, 0x11, 0x12.
  - Response: 0x10 is in main and 0x11 in skid; in_ready=0 so 0x12 is held upstream.
  - Stimulus: release out_ready.
  - Response: output order 0x10, 0x11, 0x12; stall_cnt equals the number of stalled cycles.
- Flush in FULL with simultaneous in_valid (tag 0x20):
  - Response next cycle: out_valid=0, out_ctrl=0 with KILL_MASK=3'b111, in_ready=1, and 0x20 never appears at the output.
- Partial kill mask:
  - Stimulus: KILL_MASK=3'b101, main_ctrl=3'b111, then drain.
  - Response: out_ctrl=3'b010 while out_valid=0.
- Counter saturation (CNT_W=4):
  - Stimulus: hold out_valid=1, out_ready=0 for 20 cycles.
  - Response: stall_cnt reaches 4'hF and stays there; a following flush leaves it at 4'hF.
